// File: rtl/even_seq_checker.sv
// Receive-side checker for the even-number sequence stream: locks after LOCK_COUNT
// correct increments, then flags and counts breaks. Optional macro: EVEN_SEQ_CHK_STICKY_EN.
module even_seq_checker #(
   parameter int WIDTH      = 4,
   parameter int STEP       = 2,
   parameter int LOCK_COUNT = 3,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     seq_in,
   input  logic                 seq_valid,
   output logic                 locked,
   output logic                 error,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [WIDTH-1:0]     expected
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int                   MCW     = $clog2(LOCK_COUNT + 1);
   localparam logic [WIDTH-1:0]     STEP_V  = WIDTH'(STEP);
   localparam logic [MCW-1:0]       LOCK_V  = MCW'(LOCK_COUNT);
   localparam logic [MCW-1:0]       MC_ONE  = MCW'(1);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

`ifdef EVEN_SEQ_CHK_STICKY_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   // A sample matches only if it is the predicted successor and is even.
   function automatic logic is_match(input logic [WIDTH-1:0] smp,
                                     input logic [WIDTH-1:0] pred);
      return (smp == pred) && (smp[0] == 1'b0);
   endfunction

   state_t           state_r;
   logic [MCW-1:0]   match_cnt_r;
   logic             match_s;
   logic [MCW-1:0]   match_inc_s;

   // The expected register holds prev + STEP, so prev itself need not be stored.
   assign match_s     = is_match(seq_in, expected);
   assign match_inc_s = match_cnt_r + MC_ONE;

   // Lock FSM with registered outputs; stalls hold everything except a pulsed error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         match_cnt_r <= '0;
         locked      <= 1'b0;
         error       <= 1'b0;
         err_count   <= '0;
         expected    <= STEP_V;
      end else if (seq_valid) begin
         expected <= seq_in + STEP_V;
         error    <= STICKY & error;
         case (state_r)
            IDLE: begin
               state_r     <= SEARCH;
               match_cnt_r <= '0;
               locked      <= 1'b0;
            end
            SEARCH: begin
               if (match_s) begin
                  if (match_inc_s == LOCK_V) begin
                     state_r     <= LOCKED;
                     match_cnt_r <= '0;
                     locked      <= 1'b1;
                  end else begin
                     match_cnt_r <= match_inc_s;
                  end
               end else begin
                  match_cnt_r <= '0;
               end
            end
            LOCKED: begin
               if (!match_s) begin
                  error       <= 1'b1;
                  state_r     <= SEARCH;
                  match_cnt_r <= '0;
                  locked      <= 1'b0;
                  if (err_count != CNT_MAX) begin
                     err_count <= err_count + CNT_ONE;
                  end else begin
                     err_count <= err_count;
                  end
               end else begin
                  locked <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               match_cnt_r <= '0;
               locked      <= 1'b0;
            end
         endcase
      end else begin
         error <= STICKY & error;
      end
   end

endmodule

// File: tb/tb_even_seq_checker.sv
// Directed-vector bench for even_seq_checker; a second instance with a 2-bit
// error counter covers saturation. Honours EVEN_SEQ_CHK_STICKY_EN if defined.
module tb_even_seq_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       seq_valid;
   logic [3:0] seq_in;
   logic       locked, error;
   logic [7:0] err_count;
   logic [3:0] expected;
   logic       locked2, error2;
   logic [1:0] err_count2;
   logic [3:0] expected2;

   int n_chk = 0;
   int n_bad = 0;
   bit seen  = 1'b0;

`ifdef EVEN_SEQ_CHK_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   always #5 clk = ~clk;

   even_seq_checker dut (
      .clk(clk), .reset(reset), .seq_in(seq_in), .seq_valid(seq_valid),
      .locked(locked), .error(error), .err_count(err_count), .expected(expected)
   );

   even_seq_checker #(.ERR_CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .seq_in(seq_in), .seq_valid(seq_valid),
      .locked(locked2), .error(error2), .err_count(err_count2), .expected(expected2)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] v, input logic vld);
      @(negedge clk);
      seq_in    = v;
      seq_valid = vld;
      @(posedge clk);
      #1;
   endtask

   // pulse = a LOCKED mismatch is expected on this sample
   task automatic check_out(input string tag, input logic lk, input logic pulse,
                            input int cnt, input logic [3:0] ex);
      logic e;
      e = pulse | (STICKY & seen);
      if (pulse) seen = 1'b1;
      check_val({tag, ".locked"},   locked,    lk);
      check_val({tag, ".error"},    error,     e);
      check_val({tag, ".err_count"}, err_count, cnt);
      check_val({tag, ".expected"}, expected,  ex);
   endtask

   task automatic check_sat(input string tag, input logic lk, input logic pulse, input int cnt);
      check_val({tag, ".locked2"},    locked2,    lk);
      check_val({tag, ".error2"},     error2,     pulse | (STICKY & seen));
      check_val({tag, ".err_count2"}, err_count2, cnt);
   endtask

   initial begin
      logic [3:0] v;
      reset     = 1'b1;
      seq_valid = 1'b0;
      seq_in    = 4'd0;
      @(posedge clk);
      #1;
      check_out("rst", 1'b0, 1'b0, 0, 4'd2);
      @(negedge clk);
      reset = 1'b0;

      // basic lock
      send(4'd0, 1'b1); check_out("lock0", 1'b0, 1'b0, 0, 4'd2);
      send(4'd2, 1'b1); check_out("lock2", 1'b0, 1'b0, 0, 4'd4);
      send(4'd4, 1'b1); check_out("lock4", 1'b0, 1'b0, 0, 4'd6);
      send(4'd6, 1'b1); check_out("lock6", 1'b1, 1'b0, 0, 4'd8);
      send(4'd8, 1'b1); check_out("lock8", 1'b1, 1'b0, 0, 4'd10);

      // wrap-around
      send(4'd10, 1'b1); check_out("wrap10", 1'b1, 1'b0, 0, 4'd12);
      send(4'd12, 1'b1); check_out("wrap12", 1'b1, 1'b0, 0, 4'd14);
      send(4'd14, 1'b1); check_out("wrap14", 1'b1, 1'b0, 0, 4'd0);
      send(4'd0,  1'b1); check_out("wrap0",  1'b1, 1'b0, 0, 4'd2);
      send(4'd2,  1'b1); check_out("wrap2",  1'b1, 1'b0, 0, 4'd4);

      // single break at 12, re-lock measured from it
      send(4'd4,  1'b1); check_out("brk4",  1'b1, 1'b0, 0, 4'd6);
      send(4'd6,  1'b1); check_out("brk6",  1'b1, 1'b0, 0, 4'd8);
      send(4'd8,  1'b1); check_out("brk8",  1'b1, 1'b0, 0, 4'd10);
      send(4'd12, 1'b1); check_out("brk12", 1'b0, 1'b1, 1, 4'd14);
      send(4'd14, 1'b1); check_out("brk14", 1'b0, 1'b0, 1, 4'd0);
      send(4'd0,  1'b1); check_out("brk0",  1'b0, 1'b0, 1, 4'd2);
      send(4'd2,  1'b1); check_out("brk2",  1'b1, 1'b0, 1, 4'd4);

      // stall with odd data, then match, then odd value
      send(4'd4, 1'b1); check_out("st4", 1'b1, 1'b0, 1, 4'd6);
      for (int i = 0; i < 3; i++) begin
         send(4'd9, 1'b0); check_out("stall", 1'b1, 1'b0, 1, 4'd6);
      end
      send(4'd6, 1'b1); check_out("st6", 1'b1, 1'b0, 1, 4'd8);
      send(4'd7, 1'b1); check_out("odd7", 1'b0, 1'b1, 2, 4'd9);

      // nothing after an odd prev can match; first even sample restarts the run
      send(4'd8,  1'b1); check_out("re8",  1'b0, 1'b0, 2, 4'd10);
      send(4'd10, 1'b1); check_out("re10", 1'b0, 1'b0, 2, 4'd12);
      send(4'd12, 1'b1); check_out("re12", 1'b0, 1'b0, 2, 4'd14);
      send(4'd14, 1'b1); check_out("re14", 1'b1, 1'b0, 2, 4'd0);

      // asynchronous reset between edges
      @(negedge clk);
      seq_valid = 1'b0;
      reset     = 1'b1;
      #1;
      seen = 1'b0;
      check_out("arst", 1'b0, 1'b0, 0, 4'd2);
      reset = 1'b0;
      send(4'd0, 1'b1); check_out("ar0", 1'b0, 1'b0, 0, 4'd2);
      send(4'd2, 1'b1); check_out("ar2", 1'b0, 1'b0, 0, 4'd4);
      send(4'd4, 1'b1); check_out("ar4", 1'b0, 1'b0, 0, 4'd6);
      send(4'd6, 1'b1); check_out("ar6", 1'b1, 1'b0, 0, 4'd8);
      check_sat("sat_start", 1'b1, 1'b0, 0);

      // saturation: five break/re-lock rounds on the 2-bit counter instance
      v = 4'd6;
      for (int i = 0; i < 5; i++) begin
         v = v + 4'd4;
         send(v, 1'b1);
         check_out("sat_brk", 1'b0, 1'b1, i + 1, v + 4'd2);
         check_sat("sat_brk", 1'b0, 1'b1, (i < 3) ? i + 1 : 3);
         for (int k = 0; k < 3; k++) begin
            v = v + 4'd2;
            send(v, 1'b1);
         end
         check_sat("sat_relock", 1'b1, 1'b0, (i < 3) ? i + 1 : 3);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/even_seq_checker.md
# even_seq_checker

Receive-side checker for the 4-bit even-number sequence stream produced by `even_seq_gen`: 0, 2, 4 … 14, 0 …. It samples the stream every clock and locks once it sees a run of correct increments. After lock it flags every break in the sequence and keeps a saturating count of breaks. It sits on the generator's output bus in the testbench and in system-level self-check.

## Interface
- `WIDTH`, 4: stream width in bits.
- `STEP`, 2: required increment between consecutive samples, modulo 2^WIDTH.
- `LOCK_COUNT`, 3: number of consecutive correct increments needed to lock (≥1).
- `ERR_CNT_W`, 8: width of the error counter.

Ports:
- `clk`  in  1  single clock; all sampling on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `seq_in`  in  WIDTH  stream under check.
- `seq_valid`  in  1  `seq_in` is sampled only in cycles where this is high; low = stall.
- `locked`  out  1  high while in LOCKED.
- `error`  out  1  mismatch flag (pulse or sticky; see Configuration).
- `err_count`  out  ERR_CNT_W  number of mismatches detected in LOCKED; saturating.
- `expected`  out  WIDTH  value the next valid sample must equal (`prev + STEP`, mod 2^WIDTH).

## Operation
- Internal state: `prev` register (WIDTH), `match_cnt` (wide enough for LOCK_COUNT), FSM state.
- A valid sample **matches** when `seq_in == (prev + STEP) mod 2^WIDTH` **and** `seq_in[0] == 0`. Addition truncates to WIDTH, so 14 → 0 is a match.
- On every valid sample, `prev <= seq_in`, in all states.
- **FSM states:**
  - **IDLE** (reset state): the first valid sample is captured into `prev`; go to SEARCH with `match_cnt = 0`. This sample is never judged.
  - **SEARCH**:
    - On a match, `match_cnt++`. When the incremented value equals LOCK_COUNT, go to LOCKED and clear `match_cnt`.
    - On a mismatch, `match_cnt = 0` and stay in SEARCH.
    - No error is ever flagged in SEARCH.
  - **LOCKED**:
    - On a match, stay.
    - On a mismatch:
      - raise `error`;
      - increment `err_count` unless it is all-ones;
      - go to SEARCH with `match_cnt = 0`.
    - The mismatching sample becomes `prev`, so re-lock measures from it.
- When `seq_valid` is low, the FSM, `prev`, `match_cnt` and `err_count` all hold. In pulse mode, `error` is low in a stall cycle.

## Timing
- All outputs are registered. Response latency is 1 cycle: for a sample taken at edge k, `locked`, `error`, `err_count` and `expected` reflect it from edge k through edge k+1.
- With LOCK_COUNT = 3, a correct stream starting at the first valid edge after reset asserts `locked` after the 4th valid edge.
- Reset values: `locked` = 0, `error` = 0, `err_count` = 0, `expected` = STEP (as if `prev` = 0), FSM = IDLE.
- Reset asserted mid-stream: all outputs go to their reset values asynchronously, without waiting for a clock edge. After deassertion, the first valid edge is handled as IDLE.
- The first valid edge after reset deassertion is sampled normally; no extra dead cycle.
- A mismatch in LOCKED and its drop to SEARCH take effect on the same edge: `locked` falls in the same cycle that `error` rises.
- `err_count` at all-ones: further mismatches still raise `error`, and the count holds.

## Configuration
- `EVEN_SEQ_CHK_STICKY_EN` defined:
  - `error` is sticky. It sets on the first LOCKED mismatch and stays high until `reset`.
  - `err_count` and re-lock behaviour are unchanged.
- Not defined: `error` is a one-cycle pulse per LOCKED mismatch.

## Test plan
- **Basic lock.** Reset for 1 cycle, then stream 0,2,4,6,8 with `seq_valid` = 1.
  - `locked` rises after the 4th edge (sample 6).
  - `error` = 0, `err_count` = 0 throughout.
  - `expected` = 8 when the sample 8 is presented.
- **Wrap-around.** Locked stream …, 12, 14, 0, 2.
  - No error across the 14 → 0 boundary.
  - `locked` stays 1.
- **Single break.** Locked, then stream 6, 8, 12, 14, 0, 2.
  - One-cycle `error` after sample 12; `err_count` = 1; `locked` drops to 0.
  - Re-lock from 12: `locked` rises after sample 2 (14, 0, 2 are the three matches).
  - With `EVEN_SEQ_CHK_STICKY_EN`, `error` stays 1 until reset.
- **Odd value and stall.**
  - Locked at 4, then `seq_valid` = 0 for 3 cycles with `seq_in` = 9: no state change.
  - Then valid 6: match.
  - Then valid 7: error, `err_count` increments.
- **Saturation.** Force ERR_CNT_W = 2 and inject 5 lock/break cycles.
  - `err_count` sequence is 1, 2, 3, 3, 3.
  - `error` is pulsed each time.
- **Async reset mid-operation.** Assert `reset` between edges while locked with `err_count` = 2.
  - `locked`, `error` and `err_count` are 0 before the next edge.
  - `expected` = 2.
  - After deassertion, the stream 0,2,4,6 re-locks normally.
